frame_to_demux_loader: RTL



---
 rtl/dsp_pkg.sv | 21 ++
 rtl/frame_to_demux_loader_if.sv | 25 ++
 rtl/frame_timeout_counter.sv | 42 ++++
 rtl/frame_to_demux_loader.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/dsp_pkg.sv
// Shared DSP datapath definitions: byte width, frame loader FSM encoding,
// framing defaults and the additive checksum helper.
package dsp_pkg;

    localparam int unsigned BYTE_W = 8;

    // Frame loader FSM encoding
    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_PAYLOAD = 2'd1;
    localparam logic [1:0] ST_CHECK   = 2'd2;

    localparam logic [BYTE_W-1:0] HEADER_DEFAULT   = 8'hA5;
    localparam logic [3:0]        PARK_SEL_DEFAULT = 4'd15;

    // 8-bit additive checksum, wraps mod 256
    function automatic logic [BYTE_W-1:0] csum_add(input logic [BYTE_W-1:0] acc,
                                                   input logic [BYTE_W-1:0] b);
        return acc + b;
    endfunction

endpackage

// File: rtl/frame_to_demux_loader_if.sv
// Byte-stream input and demux-side output bundle of the frame loader.
// slave: the loader itself; master: the UART/demux environment around it.
interface frame_to_demux_loader_if;
    import dsp_pkg::*;

    logic [BYTE_W-1:0] rx_data;
    logic              rx_valid;
    logic [BYTE_W-1:0] dmx_data;
    logic [3:0]        dmx_sel;
    logic              dmx_we;
    logic              busy;
    logic              frame_done;
    logic              frame_err;

    modport slave (
        input  rx_data, rx_valid,
        output dmx_data, dmx_sel, dmx_we, busy, frame_done, frame_err
    );

    modport master (
        output rx_data, rx_valid,
        input  dmx_data, dmx_sel, dmx_we, busy, frame_done, frame_err
    );

endinterface

// File: rtl/frame_timeout_counter.sv
// Loadable up/down counter with synchronous clear and an expiry flag that is
// high while the count equals the supplied limit.
module frame_timeout_counter #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    input  logic             up,
    input  logic [WIDTH-1:0] limit,
    output logic             expired
);

    logic [WIDTH-1:0] count_q, count_d;

    // Next count: clear beats load beats count
    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (load) begin
            count_d = load_val;
        end else if (en) begin
            count_d = up ? count_q + WIDTH'(1) : count_q - WIDTH'(1);
        end
    end

    // Count register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired = (count_q == limit);

endmodule

// File: rtl/frame_to_demux_loader.sv
// Frame recogniser feeding the 1-to-14 byte demux. Each accepted payload byte
// is placed on dmx_data first; one cycle later dmx_sel carries the index with
// dmx_we, and the cycle after that dmx_sel parks again while data still holds.
module frame_to_demux_loader
    import dsp_pkg::*;
#(
    parameter int unsigned       NUM_WORDS = 14,
    parameter logic [BYTE_W-1:0] HEADER    = HEADER_DEFAULT,
    parameter logic [3:0]        PARK_SEL  = PARK_SEL_DEFAULT,
    parameter logic [15:0]       TIMEOUT   = 16'd50000
) (
    input logic                    clk,
    input logic                    rst,
    frame_to_demux_loader_if.slave bus
);

    localparam logic [3:0]  LAST_IDX  = 4'(NUM_WORDS - 1);
    // Expiry is seen one cycle before the count would reach TIMEOUT so the
    // error lands exactly TIMEOUT edges after the last accepted byte.
    localparam logic [15:0] TMO_LIMIT = TIMEOUT - 16'd1;

    logic [1:0]        state_q, state_d;
    logic [3:0]        idx_q, idx_d;
    logic [BYTE_W-1:0] sum_q, sum_d;
    logic              pend_q, pend_d;
    logic              ovr_q, ovr_d;
    logic [BYTE_W-1:0] dmx_data_q, dmx_data_d;
    logic [3:0]        dmx_sel_q, dmx_sel_d;
    logic              dmx_we_q, dmx_we_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic              accept;
    logic              tmr_clr, tmr_en, tmr_expired;

    assign tmr_clr = (state_q == ST_IDLE) || accept;
    assign tmr_en  = (state_q != ST_IDLE);

    frame_timeout_counter #(
        .WIDTH (16)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .clr      (tmr_clr),
        .load     (1'b0),
        .load_val ('0),
        .en       (tmr_en),
        .up       (1'b1),
        .limit    (TMO_LIMIT),
        .expired  (tmr_expired)
    );

    // Frame FSM, write sequencer, checksum and pulse generation
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        sum_d      = sum_q;
        ovr_d      = ovr_q;
        dmx_data_d = dmx_data_q;
        pend_d     = 1'b0;
        dmx_we_d   = pend_q;
        dmx_sel_d  = pend_q ? idx_q : PARK_SEL;
        done_d     = 1'b0;
        err_d      = 1'b0;
        accept     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.rx_valid && (bus.rx_data == HEADER)) begin
                    state_d = ST_PAYLOAD;
                    idx_d   = '0;
                    sum_d   = '0;
                    ovr_d   = 1'b0;
                    accept  = 1'b1;
                end
            end
            ST_PAYLOAD: begin
                // Write cycle ending: advance index, decide where to go next
                if (dmx_we_q) begin
                    idx_d = idx_q + 4'd1;
                    if (ovr_q) begin
                        state_d = ST_IDLE;
                    end else if (idx_q == LAST_IDX) begin
                        state_d = ST_CHECK;
                    end
                end
                if (bus.rx_valid) begin
                    if (pend_q || dmx_we_q) begin
                        // Overrun: drop the byte, flag once, finish the write
                        err_d = !ovr_q;
                        ovr_d = 1'b1;
                        if (dmx_we_q) begin
                            state_d = ST_IDLE;
                        end
                    end else begin
                        dmx_data_d = bus.rx_data;
                        sum_d      = csum_add(sum_q, bus.rx_data);
                        pend_d     = 1'b1;
                        accept     = 1'b1;
                    end
                end else if (tmr_expired && !pend_q && !dmx_we_q) begin
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            ST_CHECK: begin
                if (bus.rx_valid) begin
                    accept  = 1'b1;
                    done_d  = (bus.rx_data == sum_q);
                    err_d   = (bus.rx_data != sum_q);
                    state_d = ST_IDLE;
                end else if (tmr_expired) begin
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            idx_q      <= '0;
            sum_q      <= '0;
            pend_q     <= 1'b0;
            ovr_q      <= 1'b0;
            dmx_data_q <= '0;
            dmx_sel_q  <= PARK_SEL;
            dmx_we_q   <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            sum_q      <= sum_d;
            pend_q     <= pend_d;
            ovr_q      <= ovr_d;
            dmx_data_q <= dmx_data_d;
            dmx_sel_q  <= dmx_sel_d;
            dmx_we_q   <= dmx_we_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    assign bus.dmx_data   = dmx_data_q;
    assign bus.dmx_sel    = dmx_sel_q;
    assign bus.dmx_we     = dmx_we_q;
    assign bus.busy       = (state_q != ST_IDLE);
    assign bus.frame_done = done_q;
    assign bus.frame_err  = err_q;

endmodule
